ff_share_arbiter: RTL



---
 rtl/ff_share_arb_pkg.sv | 36 +++
 rtl/ff_share_arbiter_rr_picker.sv | 20 ++
 rtl/ff_share_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ff_share_arb_pkg.sv
// Shared types and the round-robin search function for ff_share_arbiter.
// The search is written for up to 16 requesters; callers zero-extend narrower vectors.
package ff_share_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_REQ   = 16;
  localparam int unsigned MAX_IDX_W = 4;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } pick_t;

  // First set req[k] for k = ptr, ptr+1, ... wrapping modulo n (ptr must be < n).
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                    input logic [MAX_IDX_W-1:0] ptr,
                                    input int unsigned          n);
    pick_t       r;
    int unsigned k;
    r = '0;
    for (int unsigned off = 0; off < MAX_REQ; off++) begin
      k = {28'd0, ptr} + off;
      if (k >= n) k = k - n;
      if (off < n && !r.valid && req[k[MAX_IDX_W-1:0]]) begin
        r.valid = 1'b1;
        r.idx   = k[MAX_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ff_share_arbiter_rr_picker.sv
// Combinational round-robin search: first active request at or after ptr_i, wrapping.
module rr_picker
  import ff_share_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  pick_t pick;

  assign pick    = rr_pick(MAX_REQ'(req_i), MAX_IDX_W'(ptr_i), N_REQ);
  assign valid_o = pick.valid;
  assign idx_o   = pick.idx[IDX_W-1:0];

endmodule

// File: rtl/ff_share_arbiter.sv
// Round-robin arbiter sharing one registered output flop among N_REQ requesters.
// Define FF_SHARE_ARB_ASSERT_EN to emit inline SVA checks of the grant/data contract.
module ff_share_arbiter
  import ff_share_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 1,
  parameter int BURST  = 2
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   data,
  output logic [N_REQ-1:0]          gnt,
  output logic [DATA_W-1:0]         O,
  output logic                      O_valid,
  output logic [$clog2(N_REQ)-1:0]  O_src,
  output logic                      dbg_state_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (BURST > 1) ? $clog2(BURST + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [DATA_W-1:0]   o_q;
  logic                o_valid_q;
  logic [IDX_W-1:0]    o_src_q;

  logic                beat, release_own;
  logic [IDX_W-1:0]    owner_inc, pick_ptr, pick_idx;
  logic                pick_valid;
  logic [N_REQ-1:0]    pick_onehot;
  logic [DATA_W-1:0]   data_sel;

  assign beat        = gnt_q[owner_q] && req[owner_q];
  assign release_own = !req[owner_q] || (beat && cnt_q == CNT_LAST);
  assign owner_inc   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
  // While busy the only pick that matters is the re-pick on release, which
  // searches from owner+1 so the current owner is considered last.
  assign pick_ptr    = (state_q == BUSY) ? owner_inc : ptr_q;

  rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
    .req_i   (req),
    .ptr_i   (pick_ptr),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    pick_onehot = '0;
    data_sel    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_onehot[i] = 1'b1;
      if (owner_q == IDX_W'(i)) data_sel = data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_valid) begin
          state_d = BUSY;
          owner_d = pick_idx;
          gnt_d   = pick_onehot;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (release_own) begin
          ptr_d = owner_inc;
          cnt_d = '0;
          if (pick_valid) begin
            owner_d = pick_idx;
            gnt_d   = pick_onehot;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (beat) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      o_src_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      o_valid_q <= beat;
      if (beat) begin
        o_q     <= data_sel;
        o_src_q <= owner_q;
      end
    end
  end

  assign gnt         = gnt_q;
  assign O           = o_q;
  assign O_valid     = o_valid_q;
  assign O_src       = o_src_q;
  assign dbg_state_o = logic'(state_q);

`ifdef FF_SHARE_ARB_ASSERT_EN
  a_gnt_onehot0: assert property (@(posedge CLK) disable iff (RESET) $onehot0(gnt));
  a_no_req_no_valid: assert property (@(posedge CLK) disable iff (RESET) !(|req) |-> ##1 !O_valid);
  a_cnt_max: assert property (@(posedge CLK) disable iff (RESET) cnt_q <= CNT_LAST);
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_beat_chk
    a_beat_out: assert property (@(posedge CLK) disable iff (RESET)
      (gnt[gi] && req[gi]) |-> ##1 (O_valid && O_src == IDX_W'(gi) &&
                                    O == $past(data[gi*DATA_W +: DATA_W])));
  end
`endif

endmodule
